// File: rtl/io_input_debounce_if.sv
// io_input_debounce_if: raw switch inputs, flag clear and debounced outputs
interface io_input_debounce_if;
  logic [9:0] sw_raw;
  logic       clr_chg;
  logic [4:0] in_port0;
  logic [4:0] in_port1;
  logic       chg0;
  logic       chg1;
  logic [9:0] rise_pulse;
  logic [7:0] evt_count;
  modport master (
    output sw_raw, clr_chg,
    input  in_port0, in_port1, chg0, chg1, rise_pulse, evt_count
  );
  modport slave (
    input  sw_raw, clr_chg,
    output in_port0, in_port1, chg0, chg1, rise_pulse, evt_count
  );
endinterface

// File: rtl/io_input_debounce.sv
// io_input_debounce: 10-bit switch synchronizer/debouncer with change flags, rise pulses and event count
module io_input_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input logic                clock,
  input logic                resetn,
  io_input_debounce_if.slave bus
);
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  logic [9:0]    sync1_q, sync2_q, stb_q, stb_d, rise_q, rise_d;
  logic [CW-1:0] cnt_q [10];
  logic [CW-1:0] cnt_d [10];
  logic          chg0_q, chg0_d, chg1_q, chg1_d;
  logic [7:0]    evt_q, evt_d;
  logic [3:0]    pop;
  logic [8:0]    sum;
  always_comb begin
    stb_d = stb_q;
    for (int i = 0; i < 10; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stb_q[i]) begin
        if (32'(cnt_q[i]) + 32'd1 == DB_CYCLES) stb_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise_d = stb_d & ~stb_q;
    pop = '0;
    for (int j = 0; j < 10; j++) pop = pop + 4'(rise_d[j]);
    sum = 9'(evt_q) + 9'(pop);
    evt_d = sum[8] ? 8'hFF : sum[7:0];
    // a change on the clearing edge wins over the clear
    chg0_d = (|(stb_d[4:0] ^ stb_q[4:0])) | (chg0_q & ~bus.clr_chg);
    chg1_d = (|(stb_d[9:5] ^ stb_q[9:5])) | (chg1_q & ~bus.clr_chg);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stb_q   <= '0;
      rise_q  <= '0;
      cnt_q   <= '{default: '0};
      chg0_q  <= 1'b0;
      chg1_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      sync1_q <= bus.sw_raw;
      sync2_q <= sync1_q;
      stb_q   <= stb_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
      chg0_q  <= chg0_d;
      chg1_q  <= chg1_d;
      evt_q   <= evt_d;
    end
  end
  assign bus.in_port0   = stb_q[4:0];
  assign bus.in_port1   = stb_q[9:5];
  assign bus.chg0       = chg0_q;
  assign bus.chg1       = chg1_q;
  assign bus.rise_pulse = rise_q;
  assign bus.evt_count  = evt_q;
endmodule

// File: tb/tb_io_input_debounce.sv
// tb_io_input_debounce: directed vector table plus hand sequences for saturation and mid-count reset
module tb_io_input_debounce;
  typedef struct packed {
    logic [4:0] in0;
    logic [4:0] in1;
    logic       c0;
    logic       c1;
    logic [9:0] rise;
    logic [7:0] evt;
  } outs_t;
  typedef struct {
    string      nm;
    logic [9:0] sw;
    logic       clr;
    outs_t      ex;
  } vec_t;
  logic clock;
  logic resetn;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  io_input_debounce_if bus ();
  io_input_debounce #(.DB_CYCLES(4)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic outs_t mk(logic [4:0] i0, logic [4:0] i1, logic c0, logic c1,
                               logic [9:0] r, logic [7:0] e);
    outs_t o;
    o.in0 = i0; o.in1 = i1; o.c0 = c0; o.c1 = c1; o.rise = r; o.evt = e;
    return o;
  endfunction
  function automatic void add(string nm, logic [9:0] sw, logic clr, outs_t ex);
    vec_t v;
    v.nm = nm; v.sw = sw; v.clr = clr; v.ex = ex;
    tbl.push_back(v);
  endfunction
  task automatic chk(string nm, outs_t ex);
    logic [29:0] got, want;
    got  = {bus.in_port0, bus.in_port1, bus.chg0, bus.chg1, bus.rise_pulse, bus.evt_count};
    want = ex;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got {in0,in1,c0,c1,rise,evt}=%h want %h at %0t", nm, got, want, $time);
    end
  endtask
  task automatic run_tbl();
    foreach (tbl[k]) begin
      bus.sw_raw  = tbl[k].sw;
      bus.clr_chg = tbl[k].clr;
      @(posedge clock);
      @(negedge clock);
      chk(tbl[k].nm, tbl[k].ex);
    end
    tbl.delete();
    bus.clr_chg = 1'b0;
  endtask
  task automatic hold(logic [9:0] sw, int n);
    bus.sw_raw = sw;
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask
  initial begin
    int evt_m;
    bus.sw_raw  = '0;
    bus.clr_chg = 1'b0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("reset", mk(0, 0, 0, 0, 0, 0));
    resetn = 1'b1;
    // single bit rise, 3-cycle glitch, clear, fall with clear on same edge, all-bit rise
    for (int i = 0; i < 5; i++) add("p0_wait", 10'h001, 0, mk(0, 0, 0, 0, 0, 0));
    add("p0_rise", 10'h001, 0, mk(5'h01, 0, 1, 0, 10'h001, 1));
    add("p0_hold", 10'h001, 0, mk(5'h01, 0, 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) add("g5_hi", 10'h021, 0, mk(5'h01, 0, 1, 0, 0, 1));
    for (int i = 0; i < 6; i++) add("g5_lo", 10'h001, 0, mk(5'h01, 0, 1, 0, 0, 1));
    add("clr", 10'h001, 1, mk(5'h01, 0, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) add("f0_wait", 10'h000, 0, mk(5'h01, 0, 0, 0, 0, 1));
    add("f0_setwin", 10'h000, 1, mk(0, 0, 1, 0, 0, 1));
    add("f0_clr", 10'h000, 1, mk(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) add("all_wait", 10'h3FF, 0, mk(0, 0, 0, 0, 0, 1));
    add("all_rise", 10'h3FF, 0, mk(5'h1F, 5'h1F, 1, 1, 10'h3FF, 11));
    add("all_hold", 10'h3FF, 0, mk(5'h1F, 5'h1F, 1, 1, 0, 11));
    run_tbl();
    evt_m = 11;
    for (int t = 0; t < 26; t++) begin
      hold(10'h000, 8);
      hold(10'h3FF, 8);
      evt_m = (evt_m + 10 > 255) ? 255 : evt_m + 10;
      chk("sat", mk(5'h1F, 5'h1F, 1, 1, 0, 8'(evt_m)));
    end
    hold(10'h000, 4);
    #2 resetn = 1'b0;
    #1 chk("rst_async", mk(0, 0, 0, 0, 0, 0));
    @(negedge clock);
    @(negedge clock);
    bus.sw_raw = 10'h3FF;
    chk("rst_hold", mk(0, 0, 0, 0, 0, 0));
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) add("rst_wait", 10'h3FF, 0, mk(0, 0, 0, 0, 0, 0));
    add("rst_rise", 10'h3FF, 0, mk(5'h1F, 5'h1F, 1, 1, 10'h3FF, 10));
    add("rst_after", 10'h3FF, 0, mk(5'h1F, 5'h1F, 1, 1, 0, 10));
    run_tbl();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_input_debounce.md
IO_INPUT_DEBOUNCE -- requirements
Module: io_input_debounce

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive synchronized cycles a bit must differ from its stable value before the stable value updates; legal range 1..65535.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sw_raw  input  10  raw board switch levels, asynchronous to clock; bits [4:0] feed port 0 and bits [9:5] feed port 1.
REQ-005 SHALL have port clr_chg  input  1  one-cycle request to clear both change flags.
REQ-006 SHALL have port in_port0  output  5  debounced stable value of sw_raw[4:0].
REQ-007 SHALL have port in_port1  output  5  debounced stable value of sw_raw[9:5].
REQ-008 SHALL have port chg0  output  1  sticky flag: in_port0 changed since last clear.
REQ-009 SHALL have port chg1  output  1  sticky flag: in_port1 changed since last clear.
REQ-010 SHALL have port rise_pulse  output  10  per-bit one-cycle pulse on a stable 0->1 transition.
REQ-011 SHALL have port evt_count  output  8  saturating count of stable rising transitions over all bits.

Function
REQ-012 Each sw_raw bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-013 Each bit SHALL own a counter of width ceil(log2(DB_CYCLES+1)), minimum 1 bit.
REQ-014 On an edge where sync2 equals the stable bit, the counter SHALL clear to 0.
REQ-015 On an edge where sync2 differs and counter+1 < DB_CYCLES, the counter SHALL increment.
REQ-016 On an edge where sync2 differs and counter+1 == DB_CYCLES, the stable bit SHALL take sync2 and the counter SHALL clear.
REQ-017 Latency: a raw change set up before edge 1 and held SHALL update the stable output at edge 2+DB_CYCLES (edge 6 at default).
REQ-018 A raw pulse shorter than DB_CYCLES synchronized cycles SHALL produce no stable change, no pulse, no flag, no count.
REQ-019 rise_pulse[i] SHALL be registered: high for exactly the one cycle after the edge where stable bit i goes 0->1, low otherwise; falling transitions produce no pulse.
REQ-020 chg0/chg1 SHALL set on the edge where any stable bit of that port changes in either direction.
REQ-021 Clearing: clr_chg high at an edge SHALL clear both flags; a simultaneous set event SHALL win, leaving that flag 1.
REQ-022 evt_count SHALL add the number of bits rising at that edge (0..10) and saturate at 255, never wrapping.
REQ-023 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL each be handled as if alone.

Reset
REQ-024 While resetn is 0: sync1, sync2, stable bits, counters, in_port0, in_port1, chg0, chg1, rise_pulse and evt_count SHALL all be 0, immediately and without a clock edge.
REQ-025 After resetn rises with sw_raw bits held at 1, those bits SHALL debounce as normal 0->1 transitions.
REQ-026 Reset asserted mid-count SHALL discard the partial count; no stable update may occur from pre-reset history.

Verification
REQ-027 Bench SHALL cover: sw_raw 0x000->0x001, held -> in_port0=5'h01 at edge 6, rise_pulse=10'h001 for one cycle, chg0=1, evt_count=1.
REQ-028 Bench SHALL cover: sw_raw[5] high for 3 cycles, then low -> in_port1 stays 0, chg1 stays 0, evt_count unchanged.
REQ-029 Bench SHALL cover: sw_raw 0x000->0x3FF held -> in_port0=in_port1=5'h1F on the same edge, rise_pulse=10'h3FF, evt_count+=10.
REQ-030 Bench SHALL cover: 26 cycles of all-bit 0/1 toggles, each held long enough to debounce -> evt_count reaches 255 and holds.
REQ-031 Bench SHALL cover: clr_chg on the same edge as a port-0 stable change -> chg0=1; clr_chg one cycle later -> chg0=0.
REQ-032 Bench SHALL cover: resetn low two cycles into a debounce count -> all outputs 0 at once; after release, full 2+DB_CYCLES latency applies again.
